// File: rtl/cfg_word_loader.sv
// CONFIG-chain word loader: deserialises TAP shift data into 16-bit words and
// runs the header/data/checksum burst protocol into the FIR coefficient file.
module cfg_word_loader #(
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic          iTck,
  input  logic          iTrst,
  input  logic          iTlr,
  input  logic          iShift,
  input  logic          iTdi,
  input  logic          iWrEn,
  output logic          oDesync,
  output logic          oCoefWe,
  output logic [AW-1:0] oCoefAddr,
  output logic [DW-1:0] oCoefData,
  output logic          oBusy,
  output logic          oDone,
  output logic          oChkErr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  localparam logic [3:0] OP_LOAD   = 4'h1;
  localparam logic [3:0] OP_DESYNC = 4'hD;

  state_e          state_q, state_d;
  logic [DW-1:0]   sr_q, sr_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [5:0]      rem_q, rem_d;
  logic [DW-1:0]   csum_q, csum_d;
  logic            we_q, we_d;
  logic [AW-1:0]   caddr_q, caddr_d;
  logic [DW-1:0]   cdata_q, cdata_d;
  logic            desync_q, desync_d;
  logic            done_q, done_d;
  logic            chkerr_q, chkerr_d;

  logic [DW-1:0]   word;
  logic            capture;
  logic [3:0]      hdr_op;
  logic [5:0]      hdr_cnt;
  logic [AW-1:0]   hdr_start;

  // The strobe cycle carries the word's last bit, so the word includes iTdi.
  assign word      = {iTdi, sr_q[DW-1:1]};
  assign capture   = iShift & iWrEn;
  assign hdr_op    = word[15:12];
  assign hdr_cnt   = word[11:6];
  assign hdr_start = word[AW-1:0];

  // NOTE: every variable gets its default before any branch, so no path
  // through this block can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    csum_d   = csum_q;
    we_d     = 1'b0;
    caddr_d  = caddr_q;
    cdata_d  = cdata_q;
    desync_d = 1'b0;
    done_d   = 1'b0;
    chkerr_d = chkerr_q;

    if (iTlr) begin
      state_d  = ST_IDLE;
      sr_d     = '0;
      addr_d   = '0;
      rem_d    = '0;
      csum_d   = '0;
      caddr_d  = '0;
      cdata_d  = '0;
      chkerr_d = 1'b0;
    end else begin
      if (iShift) sr_d = word;
      if (capture) begin
        unique case (state_q)
          ST_IDLE: begin
            if (hdr_op == OP_LOAD) begin
              if (hdr_cnt != '0) begin
                addr_d  = hdr_start;
                rem_d   = hdr_cnt;
                csum_d  = '0;
                state_d = ST_DATA;
              end else begin
                desync_d = 1'b1;
              end
            end else if (hdr_op == OP_DESYNC) begin
              desync_d = 1'b1;
            end
          end
          ST_DATA: begin
            we_d    = 1'b1;
            caddr_d = addr_q;
            cdata_d = word;
            addr_d  = addr_q + 1'b1;
            csum_d  = csum_q ^ word;
            rem_d   = rem_q - 1'b1;
            if (rem_q == 6'd1) state_d = ST_CHECK;
          end
          ST_CHECK: begin
            if (word == csum_q) done_d   = 1'b1;
            else                chkerr_d = 1'b1;
            desync_d = 1'b1;
            state_d  = ST_IDLE;
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample
  // the same pre-edge values regardless of evaluation order.
  always_ff @(posedge iTck or negedge iTrst) begin
    if (!iTrst) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      addr_q   <= '0;
      rem_q    <= '0;
      csum_q   <= '0;
      we_q     <= 1'b0;
      caddr_q  <= '0;
      cdata_q  <= '0;
      desync_q <= 1'b0;
      done_q   <= 1'b0;
      chkerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      csum_q   <= csum_d;
      we_q     <= we_d;
      caddr_q  <= caddr_d;
      cdata_q  <= cdata_d;
      desync_q <= desync_d;
      done_q   <= done_d;
      chkerr_q <= chkerr_d;
    end
  end

  assign oDesync   = desync_q;
  assign oCoefWe   = we_q;
  assign oCoefAddr = caddr_q;
  assign oCoefData = cdata_q;
  assign oDone     = done_q;
  assign oChkErr   = chkerr_q;
  assign oBusy     = (state_q == ST_DATA) || (state_q == ST_CHECK);

endmodule

// File: tb/tb_cfg_word_loader.sv
// Bench for cfg_word_loader: directed vector table, hand-written corner
// sequences and random bursts checked against a burst-level reference.
module tb_cfg_word_loader;

  localparam int AW = 5;
  localparam int DW = 16;

  logic          iTck = 1'b0;
  logic          iTrst = 1'b0;
  logic          iTlr = 1'b0;
  logic          iShift = 1'b0;
  logic          iTdi = 1'b0;
  logic          iWrEn = 1'b0;
  logic          oDesync, oCoefWe, oBusy, oDone, oChkErr;
  logic [AW-1:0] oCoefAddr;
  logic [DW-1:0] oCoefData;

  cfg_word_loader #(.AW(AW), .DW(DW)) dut (
    .iTck(iTck), .iTrst(iTrst), .iTlr(iTlr), .iShift(iShift), .iTdi(iTdi),
    .iWrEn(iWrEn), .oDesync(oDesync), .oCoefWe(oCoefWe), .oCoefAddr(oCoefAddr),
    .oCoefData(oCoefData), .oBusy(oBusy), .oDone(oDone), .oChkErr(oChkErr)
  );

  always #5 iTck = ~iTck;

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  bit            mon_en = 1'b0;
  logic [AW-1:0] got_a[$];
  logic [DW-1:0] got_d[$];
  int            got_done, got_desync, done_alone;

  always @(negedge iTck) begin
    if (mon_en) begin
      if (oCoefWe) begin
        got_a.push_back(oCoefAddr);
        got_d.push_back(oCoefData);
      end
      if (oDone) got_done++;
      if (oDesync) got_desync++;
      if (oDone && !oDesync) done_alone++;
    end
  end

  // Transaction and its expected outcome.
  logic [DW-1:0] q_words[$];
  logic [AW-1:0] exp_a[$];
  logic [DW-1:0] exp_d[$];
  int            exp_done, exp_desync;
  bit            exp_err, exp_busy;
  int            pause_word;

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge iTck);
      iShift = 1'b0; iWrEn = 1'b0;
      @(posedge iTck);
    end
  endtask

  // LSB first; optional Pause-DR after bit 7 with a stray strobe inside it.
  task automatic send_word(input logic [DW-1:0] w, input bit pause);
    for (int i = 0; i < DW; i++) begin
      if (pause && i == 7) begin
        for (int p = 0; p < 5; p++) begin
          @(negedge iTck);
          iShift = 1'b0;
          iTdi   = 1'($urandom);
          iWrEn  = (p == 2);
          @(posedge iTck);
        end
      end
      @(negedge iTck);
      iShift = 1'b1;
      iTdi   = w[i];
      iWrEn  = (i == DW - 1);
      @(posedge iTck);
    end
    @(negedge iTck);
    iShift = 1'b0; iWrEn = 1'b0;
  endtask

  task automatic tlr_pulse();
    @(negedge iTck);
    iTlr = 1'b1;
    @(negedge iTck);
    iTlr = 1'b0;
  endtask

  task automatic run_and_check(input string name);
    got_a.delete(); got_d.delete();
    got_done = 0; got_desync = 0; done_alone = 0;
    mon_en = 1'b1;
    foreach (q_words[k]) begin
      send_word(q_words[k], k == pause_word);
      if (k == 0) check({name, ".busy_after_hdr"}, 32'(oBusy), 32'(exp_busy));
      idle(2);
    end
    idle(3);
    mon_en = 1'b0;
    check({name, ".nwrites"}, got_a.size(), exp_a.size());
    for (int k = 0; k < exp_a.size() && k < got_a.size(); k++) begin
      check($sformatf("%s.addr%0d", name, k), 32'(got_a[k]), 32'(exp_a[k]));
      check($sformatf("%s.data%0d", name, k), 32'(got_d[k]), 32'(exp_d[k]));
    end
    check({name, ".done"}, got_done, exp_done);
    check({name, ".desync"}, got_desync, exp_desync);
    check({name, ".done_wo_desync"}, done_alone, 0);
    check({name, ".chkerr"}, 32'(oChkErr), 32'(exp_err));
    check({name, ".busy_end"}, 32'(oBusy), 0);
    tlr_pulse();
    if (exp_err) check({name, ".chkerr_tlr"}, 32'(oChkErr), 0);
    q_words.delete(); exp_a.delete(); exp_d.delete();
    pause_word = -1;
  endtask

  typedef struct {
    string               name;
    logic [4:0][DW-1:0]  w;
    int                  nw;
    int                  nwr;
    logic [3:0][AW-1:0]  ea;
    logic [3:0][DW-1:0]  ed;
    int                  edone;
    int                  edes;
    bit                  eerr;
    bit                  ebusy;
  } vec_t;

  vec_t vecs[6];

  // Burst-level reference: one header, N data words, one check word.
  task automatic model_burst(input logic [5:0] start, input int n, input bit bad);
    logic [DW-1:0] x, csum;
    csum = '0;
    q_words.push_back({4'h1, 6'(n), start});
    for (int k = 0; k < n; k++) begin
      x = DW'($urandom);
      q_words.push_back(x);
      csum ^= x;
      exp_a.push_back(AW'((int'(start) % (1 << AW) + k) % (1 << AW)));
      exp_d.push_back(x);
    end
    q_words.push_back(bad ? ~csum : csum);
    exp_done   = bad ? 0 : 1;
    exp_desync = 1;
    exp_err    = bad;
    exp_busy   = 1'b1;
  endtask

  initial begin
    pause_word = -1;
    vecs[0] = '{name:"good", w:{16'h0, 16'hB9F9, 16'h1234, 16'hABCD, 16'h1083}, nw:4,
                nwr:2, ea:{5'd0, 5'd0, 5'd4, 5'd3}, ed:{16'h0, 16'h0, 16'h1234, 16'hABCD},
                edone:1, edes:1, eerr:0, ebusy:1};
    vecs[1] = '{name:"badsum", w:{16'h0, 16'h0000, 16'h1234, 16'hABCD, 16'h1083}, nw:4,
                nwr:2, ea:{5'd0, 5'd0, 5'd4, 5'd3}, ed:{16'h0, 16'h0, 16'h1234, 16'hABCD},
                edone:0, edes:1, eerr:1, ebusy:1};
    vecs[2] = '{name:"wrap", w:{16'h7777, 16'h4444, 16'h2222, 16'h1111, 16'h10DF}, nw:5,
                nwr:3, ea:{5'd0, 5'd1, 5'd0, 5'd31}, ed:{16'h0, 16'h4444, 16'h2222, 16'h1111},
                edone:1, edes:1, eerr:0, ebusy:1};
    vecs[3] = '{name:"desync", w:{64'h0, 16'hD000}, nw:1, nwr:0, ea:'0, ed:'0,
                edone:0, edes:1, eerr:0, ebusy:0};
    vecs[4] = '{name:"nop", w:{64'h0, 16'h5000}, nw:1, nwr:0, ea:'0, ed:'0,
                edone:0, edes:0, eerr:0, ebusy:0};
    vecs[5] = '{name:"n0", w:{64'h0, 16'h1000}, nw:1, nwr:0, ea:'0, ed:'0,
                edone:0, edes:1, eerr:0, ebusy:0};

    repeat (3) @(negedge iTck);
    check("rst.outs", {oCoefWe, oDone, oDesync, oChkErr, oBusy}, 0);
    check("rst.addr", 32'(oCoefAddr), 0);
    iTrst = 1'b1;

    foreach (vecs[v]) begin
      for (int k = 0; k < vecs[v].nw; k++) q_words.push_back(vecs[v].w[k]);
      for (int k = 0; k < vecs[v].nwr; k++) begin
        exp_a.push_back(vecs[v].ea[k]);
        exp_d.push_back(vecs[v].ed[k]);
      end
      exp_done = vecs[v].edone; exp_desync = vecs[v].edes;
      exp_err = vecs[v].eerr; exp_busy = vecs[v].ebusy;
      run_and_check(vecs[v].name);
    end

    // Pause-DR plus stray strobe in the middle of a data word.
    q_words = '{16'h1083, 16'hABCD, 16'h1234, 16'hB9F9};
    exp_a = '{5'd3, 5'd4};
    exp_d = '{16'hABCD, 16'h1234};
    exp_done = 1; exp_desync = 1; exp_err = 0; exp_busy = 1;
    pause_word = 1;
    run_and_check("gated");

    // Asynchronous reset in the middle of a burst.
    send_word(16'h1083, 1'b0);
    idle(2);
    send_word(16'hABCD, 1'b0);
    idle(2);
    check("midrst.busy_before", 32'(oBusy), 1);
    #2 iTrst = 1'b0;
    #1;
    check("midrst.outs", {oCoefWe, oDone, oDesync, oChkErr, oBusy}, 0);
    check("midrst.addr", 32'(oCoefAddr), 0);
    @(negedge iTck);
    iTrst = 1'b1;
    q_words = '{16'hABCD};
    exp_done = 0; exp_desync = 0; exp_err = 0; exp_busy = 0;
    run_and_check("postrst");

    // Random mix of bursts and control words.
    for (int t = 0; t < 25; t++) begin
      int kind;
      logic [3:0] op;
      kind = $urandom_range(0, 9);
      exp_a.delete(); exp_d.delete();
      exp_done = 0; exp_desync = 0; exp_err = 0; exp_busy = 0;
      if (kind < 6) begin
        model_burst(6'($urandom), $urandom_range(1, 6), $urandom_range(0, 3) == 0);
      end else if (kind == 6) begin
        q_words.push_back({4'hD, 12'($urandom)});
        exp_desync = 1;
      end else if (kind == 7) begin
        q_words.push_back({4'h1, 6'd0, 6'($urandom)});
        exp_desync = 1;
      end else begin
        do op = 4'($urandom); while (op == 4'h1 || op == 4'hD);
        q_words.push_back({op, 12'($urandom)});
      end
      run_and_check($sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
